// File: rtl/pspin_hostmem_dma_wr_resp.sv
// Write-response tracker for the PsPIN host-memory DMA write path.
// Hands out DMA tags in a circular order, remembers the AWID for each tag,
// absorbs DMA write-descriptor status and returns AXI B responses strictly
// in allocation order (a finished entry waits behind an unfinished tail).
module pspin_hostmem_dma_wr_resp #(
  parameter int ID_WIDTH      = 8,
  parameter int BUSER_WIDTH   = 1,
  parameter int DMA_TAG_WIDTH = 16,
  parameter int TAG_COUNT     = 16
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [ID_WIDTH-1:0]              alloc_id,
  input  logic                             alloc_valid,
  output logic                             alloc_ready,
  output logic [DMA_TAG_WIDTH-1:0]         alloc_tag,
  input  logic [DMA_TAG_WIDTH-1:0]         s_axis_write_desc_status_tag,
  input  logic [3:0]                       s_axis_write_desc_status_error,
  input  logic                             s_axis_write_desc_status_valid,
  output logic [ID_WIDTH-1:0]              s_axi_bid,
  output logic [1:0]                       s_axi_bresp,
  output logic [BUSER_WIDTH-1:0]           s_axi_buser,
  output logic                             s_axi_bvalid,
  input  logic                             s_axi_bready,
  output logic [$clog2(TAG_COUNT+1)-1:0]   outstanding,
  output logic                             status_bad_tag
);

  localparam int IDX_W = $clog2(TAG_COUNT);
  localparam int CNT_W = $clog2(TAG_COUNT+1);

  // Tag table: one slot per tag, indexed by the low tag bits.
  logic [ID_WIDTH-1:0]  id_tab [TAG_COUNT];
  logic [TAG_COUNT-1:0] pending;
  logic [TAG_COUNT-1:0] done;
  logic [TAG_COUNT-1:0] err;

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             alloc_fire;
  logic             ret_fire;
  logic [IDX_W-1:0] stat_idx;
  logic             stat_ok;

  // Everything the outside world sees comes straight from registers.
  assign alloc_ready  = (count != CNT_W'(TAG_COUNT));
  assign alloc_tag    = DMA_TAG_WIDTH'(head);
  assign s_axi_bvalid = pending[tail] & done[tail];
  assign s_axi_bid    = id_tab[tail];
  assign s_axi_bresp  = err[tail] ? 2'b10 : 2'b00;
  assign s_axi_buser  = '0;
  assign outstanding  = count;

  assign alloc_fire = alloc_valid & alloc_ready;
  assign ret_fire   = s_axi_bvalid & s_axi_bready;
  assign stat_idx   = s_axis_write_desc_status_tag[IDX_W-1:0];

  // Decide whether a status strobe names a live, not-yet-completed entry.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    stat_ok = 1'b0;
    if (s_axis_write_desc_status_valid &&
        ((s_axis_write_desc_status_tag >> IDX_W) == '0)) begin
      stat_ok = pending[stat_idx] & ~done[stat_idx];
    end
  end

  // Table update: allocation, completion and retirement touch distinct slots.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the table is small and bid must read 0 out of reset, so the ids are reset too.
      for (int i = 0; i < TAG_COUNT; i++) id_tab[i] <= '0;
      pending <= '0;
      done    <= '0;
      err     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every update sees pre-edge state.
      if (alloc_fire) begin
        id_tab[head]  <= alloc_id;
        pending[head] <= 1'b1;
        done[head]    <= 1'b0;
        err[head]     <= 1'b0;
      end
      if (stat_ok) begin
        done[stat_idx] <= 1'b1;
        err[stat_idx]  <= |s_axis_write_desc_status_error;
      end
      if (ret_fire) begin
        pending[tail] <= 1'b0;
        done[tail]    <= 1'b0;
      end
    end
  end

  // Pointers and occupancy count; the pointers wrap on their natural width.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc_fire) head <= head + IDX_W'(1);
      if (ret_fire)   tail <= tail + IDX_W'(1);
      case ({alloc_fire, ret_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky flag for status strobes that match no live entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                            status_bad_tag <= 1'b0;
    else if (s_axis_write_desc_status_valid && !stat_ok) status_bad_tag <= 1'b1;
  end

endmodule
